// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register for the 5-stage MIPS pipeline. It also does
// load-use hazard detection.
//
// The stage captures the decoded control word, both register operands, the
// immediate, PC+4 and the full instruction word from ID. These registers feed
// EX, where the forwarding unit reads the rs/rt fields of the instruction.
// A bubble (all-zero instruction and control) is inserted when a branch
// flush arrives or on a load-use hazard. Two saturating counters record how
// many bubbles of each kind were inserted.
//
// Ports:
//   clk_i                rising-edge clock
//   rst_i                asynchronous active-low reset
//   IF_ID_instruction_i  instruction word currently in ID
//   IF_ID_pc4_i          PC+4 of that instruction
//   rs_data_i/rt_data_i  register-file read data
//   imm_i                sign-extended immediate
//   ctrl_i               decoder control {regWrite, memRead, memWrite,
//                        memToReg, branch, aluSrc, regDst, aluOp[2:0]}
//   flush_i              branch taken; kill the ID instruction
//   ID_EX_*_o            registered copies presented to EX
//   pc_write_o           PC enable (0 = hold PC)
//   IF_ID_write_o        IF/ID enable (0 = hold IF/ID)
//   stall_cnt_o          saturating count of load-use bubbles
//   flush_cnt_o          saturating count of flush bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      IF_ID_instruction_i,
    input  logic [31:0]      IF_ID_pc4_i,
    input  logic [31:0]      rs_data_i,
    input  logic [31:0]      rt_data_i,
    input  logic [31:0]      imm_i,
    input  logic [9:0]       ctrl_i,
    input  logic             flush_i,
    output logic [31:0]      ID_EX_instruction_o,
    output logic [31:0]      ID_EX_pc4_o,
    output logic [31:0]      ID_EX_rs_data_o,
    output logic [31:0]      ID_EX_rt_data_o,
    output logic [31:0]      ID_EX_imm_o,
    output logic [9:0]       ID_EX_ctrl_o,
    output logic             pc_write_o,
    output logic             IF_ID_write_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int MEM_READ_BIT = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [4:0] exRt_s;
    logic [4:0] idRs_s;
    logic [4:0] idRt_s;
    logic       hazard_s;
    logic       stall_s;

    // Load-use detection against the load currently sitting in ID/EX.
    // A load into $0 never produces a value worth waiting for.
    always_comb begin
        exRt_s   = ID_EX_instruction_o[20:16];
        idRs_s   = IF_ID_instruction_i[25:21];
        idRt_s   = IF_ID_instruction_i[20:16];
        hazard_s = 1'b0;
        if (ID_EX_ctrl_o[MEM_READ_BIT] && (exRt_s != 5'd0) &&
            ((exRt_s == idRs_s) || (exRt_s == idRt_s))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
        // A flush kills the dependent instruction anyway, so it must not stall.
        stall_s = hazard_s && !flush_i;
    end

    assign pc_write_o    = !stall_s;
    assign IF_ID_write_o = !stall_s;

    // Pipeline register with bubble insertion. Priority is flush, then
    // load-use stall, then normal capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ID_EX_instruction_o <= 32'd0;
            ID_EX_pc4_o         <= 32'd0;
            ID_EX_rs_data_o     <= 32'd0;
            ID_EX_rt_data_o     <= 32'd0;
            ID_EX_imm_o         <= 32'd0;
            ID_EX_ctrl_o        <= 10'd0;
        end else if (flush_i || hazard_s) begin
            // sll $0,$0,0 with all control deasserted: rd = 0 keeps the
            // forwarding unit from ever matching the bubble.
            ID_EX_instruction_o <= 32'd0;
            ID_EX_pc4_o         <= 32'd0;
            ID_EX_rs_data_o     <= 32'd0;
            ID_EX_rt_data_o     <= 32'd0;
            ID_EX_imm_o         <= 32'd0;
            ID_EX_ctrl_o        <= 10'd0;
        end else begin
            ID_EX_instruction_o <= IF_ID_instruction_i;
            ID_EX_pc4_o         <= IF_ID_pc4_i;
            ID_EX_rs_data_o     <= rs_data_i;
            ID_EX_rt_data_o     <= rt_data_i;
            ID_EX_imm_o         <= imm_i;
            ID_EX_ctrl_o        <= ctrl_i;
        end
    end

    // Saturating bubble counters. A flush bubble is not also counted as a stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= {CNT_W{1'b0}};
            flush_cnt_o <= {CNT_W{1'b0}};
        end else begin
            if (flush_i && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + CNT_ONE;
            end else begin
                flush_cnt_o <= flush_cnt_o;
            end
            if (stall_s && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end else begin
                stall_cnt_o <= stall_cnt_o;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. The counters are narrowed to 2 bits so
// saturation is reachable in a few events.
module tb_id_ex_stage;

    localparam int CNT_W = 2;

    localparam logic [31:0] ADD_8_9_10   = 32'h012A4020; // add $8,$9,$10
    localparam logic [31:0] LW_9_0_8     = 32'h8D090000; // lw  $9,0($8)
    localparam logic [31:0] LW_0_0_8     = 32'h8D000000; // lw  $0,0($8)
    localparam logic [31:0] ADD_10_9_11  = 32'h012B5020; // add $10,$9,$11
    localparam logic [31:0] ADD_8_0_0    = 32'h00004020; // add $8,$0,$0
    localparam logic [31:0] ADD_14_12_13 = 32'h018D7020; // add $14,$12,$13
    localparam logic [9:0]  CTRL_R       = 10'h208;
    localparam logic [9:0]  CTRL_LW      = 10'h350;

    logic             clk;
    logic             rst;
    logic [31:0]      ifInstr;
    logic [31:0]      ifPc4;
    logic [31:0]      rsData;
    logic [31:0]      rtData;
    logic [31:0]      imm;
    logic [9:0]       ctrl;
    logic             flush;
    logic [31:0]      exInstr;
    logic [31:0]      exPc4;
    logic [31:0]      exRs;
    logic [31:0]      exRt;
    logic [31:0]      exImm;
    logic [9:0]       exCtrl;
    logic             pcWrite;
    logic             ifIdWrite;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .IF_ID_instruction_i (ifInstr),
        .IF_ID_pc4_i         (ifPc4),
        .rs_data_i           (rsData),
        .rt_data_i           (rtData),
        .imm_i               (imm),
        .ctrl_i              (ctrl),
        .flush_i             (flush),
        .ID_EX_instruction_o (exInstr),
        .ID_EX_pc4_o         (exPc4),
        .ID_EX_rs_data_o     (exRs),
        .ID_EX_rt_data_o     (exRt),
        .ID_EX_imm_o         (exImm),
        .ID_EX_ctrl_o        (exCtrl),
        .pc_write_o          (pcWrite),
        .IF_ID_write_o       (ifIdWrite),
        .stall_cnt_o         (stallCnt),
        .flush_cnt_o         (flushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling / driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [9:0] c);
        ifInstr = ins;
        ctrl    = c;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; ifInstr = 32'd0; ifPc4 = 32'd0; rsData = 32'd0;
        rtData = 32'd0; imm = 32'd0; ctrl = 10'd0; flush = 1'b0;
        tick(); tick();
        @(negedge clk);
        rst = 1'b1;

        // Pass-through with distinct data on every field.
        drive(ADD_8_9_10, CTRL_R);
        ifPc4 = 32'h0000_0104; rsData = 32'd5; rtData = 32'd7; imm = 32'h0000_4020;
        tick();
        check("pass_instr", exInstr, ADD_8_9_10);
        check("pass_pc4",   exPc4,   32'h0000_0104);
        check("pass_rs",    exRs,    32'd5);
        check("pass_rt",    exRt,    32'd7);
        check("pass_imm",   exImm,   32'h0000_4020);
        check("pass_ctrl",  {22'd0, exCtrl}, {22'd0, CTRL_R});
        check("pass_pcw",   {31'd0, pcWrite}, 32'd1);
        check("pass_stall", {30'd0, stallCnt}, 32'd0);

        // Asynchronous reset mid-cycle clears everything before the next edge.
        #2;
        rst = 1'b0;
        #1;
        check("rst_instr", exInstr, 32'd0);
        check("rst_pc4",   exPc4,   32'd0);
        check("rst_rs",    exRs,    32'd0);
        check("rst_ctrl",  {22'd0, exCtrl}, 32'd0);
        check("rst_pcw",   {31'd0, pcWrite}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Load-use: lw $9 followed by add reading $9.
        drive(LW_9_0_8, CTRL_LW);
        tick();
        check("lu_lw_ctrl", {22'd0, exCtrl}, {22'd0, CTRL_LW});
        drive(ADD_10_9_11, CTRL_R);
        #1;
        check("lu_pcw",  {31'd0, pcWrite},   32'd0);
        check("lu_ifw",  {31'd0, ifIdWrite}, 32'd0);
        tick();
        check("lu_bub_instr", exInstr, 32'd0);
        check("lu_bub_ctrl",  {22'd0, exCtrl}, 32'd0);
        check("lu_bub_rs",    exRs, 32'd0);
        check("lu_stall",     {30'd0, stallCnt}, 32'd1);
        check("lu_pcw_after", {31'd0, pcWrite}, 32'd1);
        tick();
        check("lu_add_instr", exInstr, ADD_10_9_11);
        check("lu_add_ctrl",  {22'd0, exCtrl}, {22'd0, CTRL_R});
        check("lu_stall_hold", {30'd0, stallCnt}, 32'd1);

        // Flush wins over a simultaneous load-use hazard.
        pulseReset();
        drive(LW_9_0_8, CTRL_LW);
        tick();
        drive(ADD_10_9_11, CTRL_R);
        flush = 1'b1;
        #1;
        check("fl_pcw", {31'd0, pcWrite}, 32'd1);
        tick();
        flush = 1'b0;
        check("fl_instr", exInstr, 32'd0);
        check("fl_ctrl",  {22'd0, exCtrl}, 32'd0);
        check("fl_fcnt",  {30'd0, flushCnt}, 32'd1);
        check("fl_scnt",  {30'd0, stallCnt}, 32'd0);

        // No false stall: load into $0, then load feeding an unrelated consumer.
        drive(LW_0_0_8, CTRL_LW);
        tick();
        drive(ADD_8_0_0, CTRL_R);
        #1;
        check("nf_zero_pcw", {31'd0, pcWrite}, 32'd1);
        tick();
        check("nf_zero_instr", exInstr, ADD_8_0_0);
        drive(LW_9_0_8, CTRL_LW);
        tick();
        drive(ADD_14_12_13, CTRL_R);
        #1;
        check("nf_unrel_pcw", {31'd0, pcWrite}, 32'd1);
        tick();
        check("nf_unrel_instr", exInstr, ADD_14_12_13);
        check("nf_scnt", {30'd0, stallCnt}, 32'd0);

        // Saturation: five load-use events on a 2-bit counter stop at 3.
        pulseReset();
        for (int i = 0; i < 5; i++) begin
            drive(LW_9_0_8, CTRL_LW);
            tick();
            drive(ADD_10_9_11, CTRL_R);
            tick();
            check($sformatf("sat_cnt_%0d", i), {30'd0, stallCnt},
                  (i < 3) ? (i + 1) : 3);
            tick();
        end
        check("sat_final", {30'd0, stallCnt}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline.
- Captures decoded control, register operands and the full 32-bit instruction word from ID.
- Presents them to EX, where the forwarding unit compares ID_EX_instruction_o[25:21]/[20:16] against EX/MEM and MEM/WB rd.
- Inserts bubbles on load-use hazards and branch flushes; keeps saturating hazard counters for performance checks.

Parameters:
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- IF_ID_instruction_i  in  32  instruction word in ID.
- IF_ID_pc4_i  in  32  PC+4 of the ID instruction.
- rs_data_i  in  32  register-file read port 1.
- rt_data_i  in  32  register-file read port 2.
- imm_i  in  32  sign-extended immediate.
- ctrl_i  in  10  decoder control: [9]regWrite [8]memRead [7]memWrite [6]memToReg [5]branch [4]aluSrc [3]regDst [2:0]aluOp.
- flush_i  in  1  branch taken (resolved in MEM); kill the ID instruction.
- ID_EX_instruction_o  out  32  registered instruction word.
- ID_EX_pc4_o  out  32  registered PC+4.
- ID_EX_rs_data_o  out  32  registered rs data.
- ID_EX_rt_data_o  out  32  registered rt data.
- ID_EX_imm_o  out  32  registered immediate.
- ID_EX_ctrl_o  out  10  registered control.
- pc_write_o  out  1  PC enable (0 = hold PC).
- IF_ID_write_o  out  1  IF/ID enable (0 = hold IF/ID).
- stall_cnt_o  out  CNT_W  count of load-use bubbles, saturating.
- flush_cnt_o  out  CNT_W  count of flush bubbles, saturating.

Behaviour:
- Reset (rst_i low, asynchronous): all registered outputs go to 0, including instruction, data, control and both counters.
- A zero instruction is sll $0,$0,0: rd = 0, so the forwarding unit never matches it.
- Hazard detect, combinational on current register state:
  - hazard = ID_EX_ctrl_o[8] && ID_EX_instruction_o[20:16] != 0 && (ID_EX_instruction_o[20:16] == IF_ID_instruction_i[25:21] || == IF_ID_instruction_i[20:16]).
  - pc_write_o = IF_ID_write_o = !(hazard && !flush_i).
- Per rising edge, priority flush > hazard > normal:
  - flush_i = 1: ID_EX_instruction_o <= 0 and ID_EX_ctrl_o <= 0; data, pc4 and imm registers are don't-care but must load 0. flush_cnt_o increments. No stall is asserted that cycle, even if hazard is true.
  - hazard and no flush: bubble, same zeroing as flush. stall_cnt_o increments. PC and IF/ID are held, so the same ID instruction re-evaluates next cycle.
  - otherwise: all ID/EX registers load their corresponding inputs; latency is 1 cycle.
- The stall lasts exactly 1 cycle per load-use pair. After the bubble, ID_EX_ctrl_o[8] = 0, so hazard deasserts and the held instruction advances.
- Counters saturate at 2^CNT_W-1 with no wrap. Both counters increment in the same cycle only if each condition holds independently; per the priority above, flush suppresses the stall count.
- Load to rt=0 never stalls.
- Back-to-back loads into a consumer: each load-use pair gets its own single stall.
- Reset asserted mid-stall: outputs clear immediately. After release, pc_write_o = 1 because ctrl is 0.

Test Plan:
- Reset: drive rst_i=0 mid-cycle with nonzero registers → all outputs 0 asynchronously, before the next edge; pc_write_o=1.
- Pass-through: IF_ID_instruction_i=32'h012A4020 (add $8,$9,$10), ctrl_i=10'h208, rs/rt=5/7 → one edge later outputs equal inputs; no stall.
- Load-use: lw $9,0($8) enters (ctrl memRead=1), next ID holds add $10,$9,$11 → pc_write_o=IF_ID_write_o=0 for exactly 1 cycle; ID_EX instruction/ctrl=0 after that edge; add appears in ID_EX one edge later; stall_cnt_o=1.
- Flush beats hazard: same load-use setup with flush_i=1 in the hazard cycle → pc_write_o=1, bubble loaded, flush_cnt_o=1, stall_cnt_o=0.
- No false stall: lw $0,0($8) followed by add using $0 → no stall. lw $9 followed by an instruction using only $12/$13 → no stall.
- Saturation: CNT_W=2, force 5 load-use events → stall_cnt_o stops at 3.
